// File: rtl/alu_control_muldiv.sv
// ALU control decode for the EX stage plus sequencing of the iterative
// multiply/divide unit (HI/LO) with hazard stalls.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   valid_i             EX stage holds a real instruction
//   alu_op_i            ALUOp from main control (3 bits)
//   alu_function_i      instruction funct field (6 bits)
//   alu_operation_o     decoded ALU operation code (combinational)
//   illegal_o           valid selector not found in the decode table
//   muldiv_start_o      one-cycle launch pulse for the mul/div unit
//   muldiv_op_o         op code of the in-flight (or last) mul/div
//   muldiv_busy_o       unit computing
//   muldiv_done_o       pulse on the last busy cycle
//   stall_o             freeze IF/ID/EX; ALU result must not be written
module alu_control_muldiv #(
    parameter int         MULDIV_LATENCY = 32,
    parameter logic [3:0] DEFAULT_OP     = 4'b1001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_i,
    input  logic [2:0] alu_op_i,
    input  logic [5:0] alu_function_i,
    output logic [3:0] alu_operation_o,
    output logic       illegal_o,
    output logic       muldiv_start_o,
    output logic [3:0] muldiv_op_o,
    output logic       muldiv_busy_o,
    output logic       muldiv_done_o,
    output logic       stall_o
);

    localparam int CW = $clog2(MULDIV_LATENCY + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [3:0]    op_n;
    logic          hit;
    logic          is_md;
    logic          is_mf;

    // Decode table; the low-order funct bits are don't-cares for I-type ops.
    always_comb begin
        alu_operation_o = DEFAULT_OP;
        hit             = 1'b1;
        casez ({alu_op_i, alu_function_i})
            9'b111_100000: alu_operation_o = 4'b0011;
            9'b111_100010: alu_operation_o = 4'b0101;
            9'b111_100100: alu_operation_o = 4'b0110;
            9'b111_100101: alu_operation_o = 4'b0001;
            9'b111_101010: alu_operation_o = 4'b0111;
            9'b111_000000: alu_operation_o = 4'b0010;
            9'b111_000010: alu_operation_o = 4'b0100;
            9'b111_011000: alu_operation_o = 4'b1010;
            9'b111_011001: alu_operation_o = 4'b1011;
            9'b111_011010: alu_operation_o = 4'b1100;
            9'b111_011011: alu_operation_o = 4'b1101;
            9'b111_010000: alu_operation_o = 4'b1110;
            9'b111_010010: alu_operation_o = 4'b1111;
            9'b100_??????: alu_operation_o = 4'b0011;
            9'b000_??????: alu_operation_o = 4'b0000;
            9'b001_??????: alu_operation_o = 4'b0001;
            default:       hit = 1'b0;
        endcase
    end

    // hit gating keeps a DEFAULT_OP override from aliasing a mul/div code.
    assign illegal_o = valid_i & ~hit;
    assign is_md = valid_i & hit &
                   (alu_operation_o inside {[4'b1010:4'b1101]});
    assign is_mf = valid_i & hit &
                   (alu_operation_o inside {4'b1110, 4'b1111});

    assign muldiv_busy_o  = (state == BUSY);
    assign muldiv_done_o  = muldiv_busy_o & (cnt == CW'(1));
    assign stall_o        = muldiv_busy_o & (is_md | is_mf);
    // No launch while reset is held, even though the state reads IDLE.
    assign muldiv_start_o = ~muldiv_busy_o & is_md & ~reset;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = muldiv_op_o;
        unique case (state)
            IDLE: begin
                if (is_md) begin
                    state_n = BUSY;
                    cnt_n   = CW'(MULDIV_LATENCY);
                    op_n    = alu_operation_o;
                end
            end
            BUSY: begin
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            muldiv_op_o <= 4'b0000;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            muldiv_op_o <= op_n;
        end
    end

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Scoreboard bench for alu_control_muldiv: a cycle-numbered reference
// model predicts every cycle's outputs; a monitor compares at negedge.
module tb_alu_control_muldiv;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_i = 1'b0;
    logic [2:0] alu_op_i = 3'b000;
    logic [5:0] alu_function_i = 6'b000000;
    logic [3:0] alu_operation_o;
    logic       illegal_o;
    logic       muldiv_start_o;
    logic [3:0] muldiv_op_o;
    logic       muldiv_busy_o;
    logic       muldiv_done_o;
    logic       stall_o;

    alu_control_muldiv #(.MULDIV_LATENCY(LAT), .DEFAULT_OP(4'b1001)) dut (
        .clk(clk),
        .reset(reset),
        .valid_i(valid_i),
        .alu_op_i(alu_op_i),
        .alu_function_i(alu_function_i),
        .alu_operation_o(alu_operation_o),
        .illegal_o(illegal_o),
        .muldiv_start_o(muldiv_start_o),
        .muldiv_op_o(muldiv_op_o),
        .muldiv_busy_o(muldiv_busy_o),
        .muldiv_done_o(muldiv_done_o),
        .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] FN [0:12] = '{
        6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
        6'b000000, 6'b000010, 6'b011000, 6'b011001, 6'b011010,
        6'b011011, 6'b010000, 6'b010010};
    localparam logic [3:0] CD [0:12] = '{
        4'b0011, 4'b0101, 4'b0110, 4'b0001, 4'b0111,
        4'b0010, 4'b0100, 4'b1010, 4'b1011, 4'b1100,
        4'b1101, 4'b1110, 4'b1111};

    typedef struct {
        int         cyc;
        logic [3:0] op;
        logic       ill;
        logic       start;
        logic [3:0] mop;
        logic       busy;
        logic       done;
        logic       stall;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    // Model state: unit busy during cycles [bstart, bend].
    int         cyc = 0;
    int         bstart = 0;
    int         bend = -1;
    logic [3:0] mop = 4'b0000;

    function automatic logic [3:0] ref_decode(input logic [2:0] a,
                                              input logic [5:0] f,
                                              output logic hit);
        hit = 1'b1;
        if (a == 3'b100) return 4'b0011;
        if (a == 3'b000) return 4'b0000;
        if (a == 3'b001) return 4'b0001;
        if (a == 3'b111)
            for (int i = 0; i < 13; i++)
                if (FN[i] == f) return CD[i];
        hit = 1'b0;
        return 4'b1001;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v,
                        input logic [2:0] a, input logic [5:0] f);
        exp_t x;
        logic hit;
        logic md;
        logic mf;
        logic bz;
        @(posedge clk);
        #1;
        reset = r;
        valid_i = v;
        alu_op_i = a;
        alu_function_i = f;
        x.cyc = cyc;
        x.op = ref_decode(a, f, hit);
        x.ill = v & ~hit;
        md = v && hit && x.op >= 4'd10 && x.op <= 4'd13;
        mf = v && hit && x.op >= 4'd14;
        if (r) begin
            mop = 4'b0000;
            bend = -1;
            x.start = 1'b0;
            x.mop = 4'b0000;
            x.busy = 1'b0;
            x.done = 1'b0;
            x.stall = 1'b0;
        end else begin
            bz = (cyc >= bstart) && (cyc <= bend);
            x.busy = bz;
            x.done = bz && (cyc == bend);
            x.stall = bz && (md || mf);
            x.start = !bz && md;
            x.mop = mop;
            if (x.start) begin
                mop = x.op;
                bstart = cyc + 1;
                bend = cyc + LAT;
            end
        end
        q.push_back(x);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'b111, 6'b100000);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if ({alu_operation_o, illegal_o, muldiv_start_o, muldiv_op_o,
                 muldiv_busy_o, muldiv_done_o, stall_o} !==
                {e.op, e.ill, e.start, e.mop, e.busy, e.done, e.stall}) begin
                errors++;
                $display("FAIL cyc%0d got op=%h ill=%b start=%b mop=%h busy=%b done=%b stall=%b expected op=%h ill=%b start=%b mop=%h busy=%b done=%b stall=%b",
                         e.cyc, alu_operation_o, illegal_o, muldiv_start_o,
                         muldiv_op_o, muldiv_busy_o, muldiv_done_o, stall_o,
                         e.op, e.ill, e.start, e.mop, e.busy, e.done,
                         e.stall);
            end
        end
    end

    initial begin
        logic [2:0] a;
        logic [5:0] f;
        int k;
        step(1'b1, 1'b0, 3'b000, 6'b000000);
        step(1'b1, 1'b1, 3'b111, 6'b011000);
        #1;
        chk("reset_busy", muldiv_busy_o, 0);
        chk("reset_mop", muldiv_op_o, 0);
        chk("reset_start", muldiv_start_o, 0);
        idle(2);

        // Table sweep plus two undecodable selectors.
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 1'b1, 3'b111, FN[i]);
            idle(LAT + 1);
        end
        step(1'b0, 1'b1, 3'b111, 6'b111111);
        step(1'b0, 1'b1, 3'b010, 6'b000000);
        step(1'b0, 1'b1, 3'b100, 6'b101010);
        step(1'b0, 1'b1, 3'b000, 6'b111111);
        step(1'b0, 1'b1, 3'b001, 6'b010101);

        // MULT then independent ADDs.
        idle(2);
        step(1'b0, 1'b1, 3'b111, 6'b011000);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'b111, 6'b100000);

        // MULT then dependent MFLO.
        idle(2);
        step(1'b0, 1'b1, 3'b111, 6'b011000);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'b111, 6'b010010);

        // DIV then back-to-back DIVU.
        idle(2);
        step(1'b0, 1'b1, 3'b111, 6'b011010);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'b111, 6'b011011);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 3'b111, 6'b010000);

        // MULTU, reset asserted in the second busy cycle.
        idle(2);
        step(1'b0, 1'b1, 3'b111, 6'b011001);
        step(1'b0, 1'b1, 3'b111, 6'b010010);
        step(1'b1, 1'b1, 3'b111, 6'b010010);
        #1;
        chk("async_busy", muldiv_busy_o, 0);
        chk("async_stall", stall_o, 0);
        chk("async_mop", muldiv_op_o, 0);
        step(1'b1, 1'b1, 3'b111, 6'b100000);
        for (int i = 0; i < LAT + 2; i++)
            step(1'b0, 1'b1, 3'b111, 6'b100000);

        // valid_i low with a MULT selector, idle then busy.
        step(1'b0, 1'b0, 3'b111, 6'b011000);
        step(1'b0, 1'b1, 3'b111, 6'b011001);
        step(1'b0, 1'b0, 3'b111, 6'b011000);
        step(1'b0, 1'b0, 3'b111, 6'b010000);
        idle(LAT);

        // Random traffic, biased toward legal and mul/div selectors.
        for (int n = 0; n < 600; n++) begin
            k = $urandom_range(0, 9);
            if (k < 6) begin
                a = 3'b111;
                f = FN[$urandom_range(0, 12)];
            end else if (k < 8) begin
                a = 3'($urandom_range(0, 7));
                f = 6'($urandom);
            end else begin
                a = 3'b111;
                f = FN[$urandom_range(7, 12)];
            end
            step(($urandom_range(0, 60) == 0), ($urandom_range(0, 7) != 0),
                 a, f);
        end
        step(1'b0, 1'b0, 3'b000, 6'b000000);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
